// File: rtl/systolic_result_drain_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_result_drain_if
// Description : Memory write request bus between the result drain and the
//               memory controller write port. The drain is the master and
//               the memory controller is the slave.
// Signals     : mem_write_valid   - write request valid        (master -> slave)
//               mem_write_address - write address              (master -> slave)
//               mem_write_data    - write data                 (master -> slave)
//               mem_write_ready   - write accepted this cycle  (slave  -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_result_drain_if #(
    parameter int DATA_BITS = 16,
    parameter int ADDR_BITS = 8
);
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    modport master (
        output mem_write_valid,
        output mem_write_address,
        output mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        input  mem_write_valid,
        input  mem_write_address,
        input  mem_write_data,
        output mem_write_ready
    );
endinterface
`default_nettype wire

// File: rtl/systolic_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : systolic_result_drain
// Description : Snapshots the NxN Q1.15 accumulator matrix of the systolic
//               array on start, then writes every element to data memory in
//               row-major order over a valid/ready write bus.
// Ports       : clk          - rising-edge clock
//               rst          - asynchronous active-high reset
//               i_enable     - global enable; low freezes all state
//               i_start      - pulse: snapshot results and begin the drain
//               i_base_addr  - address of element [0][0], sampled on start
//               i_row_stride - address step between rows, sampled on start
//               i_results    - PE accumulator outputs [row][col]
//               o_busy       - high from accept of start until done
//               o_done       - one-cycle pulse after the last write accepted
//               mem          - memory write bus (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_result_drain #(
    parameter int DATA_BITS  = 16,
    parameter int ARRAY_SIZE = 4,
    parameter int ADDR_BITS  = 8
) (
    input  wire logic                                             clk,
    input  wire logic                                             rst,
    input  wire logic                                             i_enable,
    input  wire logic                                             i_start,
    input  wire logic [ADDR_BITS-1:0]                             i_base_addr,
    input  wire logic [ADDR_BITS-1:0]                             i_row_stride,
    input  wire logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][DATA_BITS-1:0] i_results,
    output logic                                                  o_busy,
    output logic                                                  o_done,
    systolic_result_drain_if.master                               mem
);

    localparam int               IDX_W  = $clog2(ARRAY_SIZE);
    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(ARRAY_SIZE - 1);
    localparam logic [IDX_W-1:0] c_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                                            r_state;
    logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][DATA_BITS-1:0] r_snap;
    logic [IDX_W-1:0]                                  r_row;
    logic [IDX_W-1:0]                                  r_col;
    logic [ADDR_BITS-1:0]                              r_row_base;
    logic [ADDR_BITS-1:0]                              r_row_stride;
    logic                                              r_busy;
    logic                                              r_done;

    // Valid is gated combinationally by enable so a frozen drain never
    // presents a request; the memory controller tolerates valid dropping.
    assign mem.mem_write_valid   = (r_state == S_WRITE) && i_enable;
    // Address and data come straight from registered state, so they hold
    // steady for as long as the current element is not accepted.
    assign mem.mem_write_address = r_row_base + ADDR_BITS'(r_col);
    assign mem.mem_write_data    = r_snap[r_row][r_col];
    assign o_busy                = r_busy;
    assign o_done                = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_snap       <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_row_base   <= '0;
            r_row_stride <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (i_enable) begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        // Snapshot lets the array clear or recompute at once.
                        r_snap       <= i_results;
                        r_row_base   <= i_base_addr;
                        r_row_stride <= i_row_stride;
                        r_row        <= '0;
                        r_col        <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Inside this branch enable is high, so valid is high and
                    // ready alone decides acceptance.
                    if (mem.mem_write_ready) begin
                        if (r_col == c_LAST) begin
                            r_col      <= '0;
                            r_row      <= r_row + c_ONE;
                            r_row_base <= r_row_base + r_row_stride;
                            if (r_row == c_LAST) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_col <= r_col + c_ONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_result_drain
// Description : Self-checking bench for systolic_result_drain. A queue of
//               expected (address, data) pairs is built from the matrix at
//               start; every write on the bus is compared with its head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_result_drain;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_enable = 1'b1;
    logic i_start = 1'b0;
    logic [AW-1:0] i_base_addr = '0;
    logic [AW-1:0] i_row_stride = '0;
    logic [N-1:0][N-1:0][DW-1:0] i_results = '0;
    logic o_busy;
    logic o_done;

    systolic_result_drain_if #(.DATA_BITS(DW), .ADDR_BITS(AW)) mif ();

    systolic_result_drain #(
        .DATA_BITS (DW),
        .ARRAY_SIZE(N),
        .ADDR_BITS (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_enable    (i_enable),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_row_stride(i_row_stride),
        .i_results   (i_results),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .mem         (mif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [AW+DW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // rmode: 0 ready held high, 1 ready toggles 1,0,1,0, 2 random ready
    task automatic run(input int pat, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                       input int rmode, input bit corrupt, input bit restart, input bit rstmode);
        int cyc, accepts, done_n, done_cyc, last_acc;
        bit done_due;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                i_results[r][c] = (pat == 0) ? DW'(16 * r + c) : DW'($urandom);
        exp_q.delete();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                exp_q.push_back({AW'(int'(base) + r * int'(stride) + c), i_results[r][c]});
        i_base_addr  = base;
        i_row_stride = stride;
        i_start      = 1'b1;
        @(posedge clk);
        #1;
        i_start      = 1'b0;
        i_base_addr  = AW'($urandom);
        i_row_stride = AW'($urandom);
        if (corrupt)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    i_results[r][c] = 16'hFFFF;
        chk("busy_after_start", {31'd0, o_busy}, 32'd1);
        cyc = 1; accepts = 0; done_n = 0; done_cyc = 0; last_acc = 0; done_due = 0;
        mif.mem_write_ready = (rmode == 1) ? 1'b1 : (rmode == 2) ? 1'($urandom) : 1'b1;
        while (cyc < 150) begin
            @(negedge clk);
            chk("valid", {31'd0, mif.mem_write_valid}, {31'd0, i_enable && (exp_q.size() != 0)});
            chk("busy", {31'd0, o_busy}, {31'd0, exp_q.size() != 0});
            chk("done", {31'd0, o_done}, {31'd0, done_due});
            if (o_done) begin
                done_n++;
                done_cyc = cyc;
            end
            done_due = 1'b0;
            if (mif.mem_write_valid && exp_q.size() != 0) begin
                chk("addr", {24'd0, mif.mem_write_address}, {24'd0, exp_q[0][AW+DW-1:DW]});
                chk("data", {16'd0, mif.mem_write_data}, {16'd0, exp_q[0][DW-1:0]});
                if (mif.mem_write_ready) begin
                    void'(exp_q.pop_front());
                    accepts++;
                    last_acc = cyc;
                    if (exp_q.size() == 0) done_due = 1'b1;
                end
            end
            if (exp_q.size() == 0 && !done_due && cyc > last_acc + 3) break;
            @(posedge clk);
            #1;
            cyc++;
            case (rmode)
                1:       mif.mem_write_ready = cyc[0];
                2:       mif.mem_write_ready = 1'($urandom);
                default: mif.mem_write_ready = 1'b1;
            endcase
            i_start = restart && (cyc == 3 || cyc == 9);
            if (rstmode) i_enable = !(cyc >= 3 && cyc <= 5);
            if (rstmode && accepts == 5) begin
                rst = 1'b1;
                #1;
                chk("rst_valid", {31'd0, mif.mem_write_valid}, 32'd0);
                chk("rst_busy", {31'd0, o_busy}, 32'd0);
                repeat (4) begin
                    @(negedge clk);
                    chk("rst_done", {31'd0, o_done}, 32'd0);
                    chk("rst_valid_hold", {31'd0, mif.mem_write_valid}, 32'd0);
                end
                @(posedge clk);
                #1;
                rst = 1'b0;
                exp_q.delete();
                return;
            end
        end
        i_start = 1'b0;
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("accepts", accepts, N * N);
        chk("done_count", done_n, 32'd1);
        chk("done_after_last", done_cyc, last_acc + 1);
        if (rmode == 0) chk("done_cycle", done_cyc, N * N + 1);
        if (rmode == 1) chk("last_accept_cycle", last_acc, 2 * N * N - 1);
    endtask

    initial begin
        mif.mem_write_ready = 1'b1;
        #12;
        chk("reset_valid", {31'd0, mif.mem_write_valid}, 32'd0);
        chk("reset_addr", {24'd0, mif.mem_write_address}, 32'd0);
        chk("reset_data", {16'd0, mif.mem_write_data}, 32'd0);
        chk("reset_busy", {31'd0, o_busy}, 32'd0);
        chk("reset_done", {31'd0, o_done}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // start while disabled is ignored
        i_enable = 1'b0;
        i_start  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        i_start = 1'b0;
        i_enable = 1'b1;
        @(negedge clk);
        chk("start_disabled_busy", {31'd0, o_busy}, 32'd0);
        chk("start_disabled_valid", {31'd0, mif.mem_write_valid}, 32'd0);

        run(0, 8'h10, 8'h04, 0, 1'b0, 1'b0, 1'b0);  // basic row-major drain
        run(0, 8'h10, 8'h04, 1, 1'b0, 1'b0, 1'b0);  // ready toggling
        run(1, 8'h10, 8'h04, 0, 1'b1, 1'b0, 1'b0);  // results overwritten after start
        run(1, 8'hFC, 8'h04, 0, 1'b0, 1'b0, 1'b0);  // address wrap
        run(1, 8'h20, 8'h08, 0, 1'b0, 1'b1, 1'b0);  // start while busy
        run(1, 8'h40, 8'h00, 0, 1'b0, 1'b0, 1'b0);  // stride zero aliases rows
        run(1, 8'h30, 8'h04, 0, 1'b0, 1'b0, 1'b1);  // enable gap then reset
        for (int k = 0; k < 4; k++)
            run(1, AW'($urandom), AW'($urandom), 2, 1'($urandom), 1'($urandom), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
